// File: rtl/match_controller.sv
// Two-player match sequencer: owns the scores, the winner code on LCD_sig,
// the serve indicator and the match timer.
module match_controller #(
  parameter int WIN_SCORE  = 11,
  parameter int MIN_LEAD   = 2,
  parameter int HOLD_CYC   = 4,
  parameter int TIME_LIMIT = 1000,
  parameter int TW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pointA,
  input  logic       pointB,
  output logic [8:0] scoreA,
  output logic [8:0] scoreB,
  output logic [1:0] LCD_sig,
  output logic       server,
  output logic       busy
);

  localparam int                HW     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [8:0]        WIN9   = 9'(WIN_SCORE);
  localparam logic [8:0]        DEUCE9 = 9'(WIN_SCORE - 1);
  localparam logic signed [9:0] LEAD10 = 10'(MIN_LEAD);
  localparam logic [TW-1:0]     T_LAST = TW'(TIME_LIMIT - 1);
  localparam logic [HW-1:0]     H_LOAD = HW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_HOLD, S_DONE} state_t;

  state_t      r_state, w_state;
  logic [8:0]  r_score_a, w_score_a, r_score_b, w_score_b;
  logic [1:0]  r_lcd, w_lcd;
  logic        r_server, w_server;
  logic        r_busy, w_busy;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic        r_tflag, w_tflag;
  logic [HW-1:0] r_hcnt, w_hcnt;
  logic        r_pc_odd, w_pc_odd;

  logic signed [9:0] w_diff_ab, w_diff_ba;
  logic        w_a_win, w_b_win, w_deuce, w_point_a, w_point_b;
  logic [1:0]  w_cmp;
  logic [8:0]  w_inc_a, w_inc_b;

  // Score margins in 10-bit signed so a trailing player never wraps to a big lead.
  assign w_diff_ab = $signed({1'b0, r_score_a}) - $signed({1'b0, r_score_b});
  assign w_diff_ba = $signed({1'b0, r_score_b}) - $signed({1'b0, r_score_a});
  assign w_a_win   = (r_score_a >= WIN9) && (w_diff_ab >= LEAD10);
  assign w_b_win   = (r_score_b >= WIN9) && (w_diff_ba >= LEAD10);
  assign w_deuce   = (r_score_a >= DEUCE9) && (r_score_b >= DEUCE9);
  assign w_cmp     = (w_diff_ab > 10'sd0) ? 2'b01 :
                     (w_diff_ab < 10'sd0) ? 2'b10 : 2'b11;
  assign w_point_a = pointA & ~pointB;
  assign w_point_b = pointB & ~pointA;
  assign w_inc_a   = (r_score_a == 9'h1FF) ? r_score_a : r_score_a + 9'd1;
  assign w_inc_b   = (r_score_b == 9'h1FF) ? r_score_b : r_score_b + 9'd1;

  always_comb begin
    // NOTE: every next-value starts as the held value so no path infers a latch.
    w_state   = r_state;
    w_score_a = r_score_a;
    w_score_b = r_score_b;
    w_lcd     = r_lcd;
    w_server  = r_server;
    w_tcnt    = r_tcnt;
    w_tflag   = r_tflag;
    w_hcnt    = r_hcnt;
    w_pc_odd  = r_pc_odd;

    if ((r_state == S_PLAY || r_state == S_CHECK || r_state == S_HOLD) && !r_tflag) begin
      if (r_tcnt == T_LAST) w_tflag = 1'b1;
      else                  w_tcnt  = r_tcnt + TW'(1);
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_IDLE || start) begin
          w_score_a = '0;
          w_score_b = '0;
          w_lcd     = 2'b00;
          w_server  = 1'b0;
          w_tcnt    = '0;
          w_tflag   = 1'b0;
          w_hcnt    = '0;
          w_pc_odd  = 1'b0;
        end
        if (start) w_state = S_PLAY;
      end
      S_PLAY: begin
        if (w_point_a) begin
          w_score_a = w_inc_a;
          w_pc_odd  = ~r_pc_odd;
          w_state   = S_CHECK;
        end else if (w_point_b) begin
          w_score_b = w_inc_b;
          w_pc_odd  = ~r_pc_odd;
          w_state   = S_CHECK;
        end else if (r_tflag) begin
          w_lcd   = w_cmp;
          w_state = S_DONE;
        end
      end
      S_CHECK: begin
        if (w_a_win) begin
          w_lcd   = 2'b01;
          w_state = S_DONE;
        end else if (w_b_win) begin
          w_lcd   = 2'b10;
          w_state = S_DONE;
        end else begin
          // Serve swaps every second point, or every point once in deuce.
          if (w_deuce || !r_pc_odd) w_server = ~r_server;
          if (r_tflag) begin
            w_lcd   = w_cmp;
            w_state = S_DONE;
          end else begin
            w_hcnt  = H_LOAD;
            w_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (r_tflag) begin
          w_lcd   = w_cmp;
          w_state = S_DONE;
        end else if (r_hcnt == '0) begin
          w_state = S_PLAY;
        end else begin
          w_hcnt = r_hcnt - HW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state == S_PLAY) || (w_state == S_CHECK) || (w_state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state   <= S_IDLE;
      r_score_a <= '0;
      r_score_b <= '0;
      r_lcd     <= 2'b00;
      r_server  <= 1'b0;
      r_busy    <= 1'b0;
      r_tcnt    <= '0;
      r_tflag   <= 1'b0;
      r_hcnt    <= '0;
      r_pc_odd  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_score_a <= w_score_a;
      r_score_b <= w_score_b;
      r_lcd     <= w_lcd;
      r_server  <= w_server;
      r_busy    <= w_busy;
      r_tcnt    <= w_tcnt;
      r_tflag   <= w_tflag;
      r_hcnt    <= w_hcnt;
      r_pc_odd  <= w_pc_odd;
    end
  end

  assign scoreA  = r_score_a;
  assign scoreB  = r_score_b;
  assign LCD_sig = r_lcd;
  assign server  = r_server;
  assign busy    = r_busy;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: a default instance for scoring/serve
// and a short-timer instance (TIME_LIMIT=50) for time-limit outcomes.
module tb_match_controller;

  typedef struct packed {
    logic [8:0] sa;
    logic [8:0] sb;
    logic [1:0] lcd;
    logic       srv;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_m = 1'b0, pa_m = 1'b0, pb_m = 1'b0;
  logic       start_t = 1'b0, pa_t = 1'b0, pb_t = 1'b0;
  logic [8:0] sa_m, sb_m, sa_t, sb_t;
  logic [1:0] lcd_m, lcd_t;
  logic       srv_m, srv_t, busy_m, busy_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int         ma, mb, mpc;
  logic       msrv, mbusy;
  logic [1:0] mlcd;

  always #5 clk = ~clk;

  match_controller dut_m (
    .clk(clk), .rst(rst), .start(start_m), .pointA(pa_m), .pointB(pb_m),
    .scoreA(sa_m), .scoreB(sb_m), .LCD_sig(lcd_m), .server(srv_m), .busy(busy_m)
  );

  match_controller #(.TIME_LIMIT(50)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .pointA(pa_t), .pointB(pb_t),
    .scoreA(sa_t), .scoreB(sb_t), .LCD_sig(lcd_t), .server(srv_t), .busy(busy_t)
  );

  function automatic exp_t obs(input bit t);
    exp_t r;
    if (t) begin
      r.sa = sa_t; r.sb = sb_t; r.lcd = lcd_t; r.srv = srv_t; r.busy = busy_t;
    end else begin
      r.sa = sa_m; r.sb = sb_m; r.lcd = lcd_m; r.srv = srv_m; r.busy = busy_m;
    end
    return r;
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("A=%0d B=%0d lcd=%b srv=%b busy=%b", v.sa, v.sb, v.lcd, v.srv, v.busy);
  endfunction

  // Transaction-level reference model of the match.
  task automatic model_start();
    ma = 0; mb = 0; mpc = 0; msrv = 1'b0; mlcd = 2'b00; mbusy = 1'b1;
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mpc = 0; msrv = 1'b0; mlcd = 2'b00; mbusy = 1'b0;
  endtask

  task automatic model_point(input bit a, input bit b);
    if (mbusy && (a ^ b)) begin
      if (a) ma = (ma < 511) ? ma + 1 : ma;
      else   mb = (mb < 511) ? mb + 1 : mb;
      mpc++;
      if (ma >= 11 && ma - mb >= 2) begin
        mlcd = 2'b01; mbusy = 1'b0;
      end else if (mb >= 11 && mb - ma >= 2) begin
        mlcd = 2'b10; mbusy = 1'b0;
      end else if ((ma >= 10 && mb >= 10) || (mpc % 2 == 0)) begin
        msrv = ~msrv;
      end
    end
  endtask

  task automatic model_timeout();
    mlcd  = (ma > mb) ? 2'b01 : (mb > ma) ? 2'b10 : 2'b11;
    mbusy = 1'b0;
  endtask

  task automatic model_push();
    exp_t e;
    e.sa = 9'(ma); e.sb = 9'(mb); e.lcd = mlcd; e.srv = msrv; e.busy = mbusy;
    sb_q.push_back(e);
  endtask

  // Inputs held for exactly one rising edge; called and returns on a falling edge.
  task automatic pulse(input bit t, input bit s, input bit a, input bit b);
    if (t) begin start_t = s; pa_t = a; pb_t = b; end
    else   begin start_m = s; pa_m = a; pb_m = b; end
    @(negedge clk);
    start_m = 1'b0; pa_m = 1'b0; pb_m = 1'b0;
    start_t = 1'b0; pa_t = 1'b0; pb_t = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, o;
    rst = 1'b0;
    idle(2);
    model_reset(); model_push(); model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_m: got %s, expected %s", fmt(o), fmt(e)); end
    e = sb_q.pop_front(); o = obs(1'b1); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_t: got %s, expected %s", fmt(o), fmt(e)); end
    rst = 1'b1;
    idle(1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL idle_point: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_straight_win();
    exp_t e, o;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    model_start(); model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL win_start: got %s, expected %s", fmt(o), fmt(e)); end
    for (int i = 1; i <= 11; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 11) begin
        o = obs(1'b0); n_tests++;
        if (o.sa !== 9'd11 || o.lcd !== 2'b00) begin
          n_fail++;
          $display("FAIL win_pre_check: got A=%0d lcd=%b, expected A=11 lcd=00", o.sa, o.lcd);
        end
      end
      model_point(1'b1, 1'b0); model_push();
      idle(1);
      e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL win_pt%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
      idle(6);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    model_point(1'b1, 1'b0); model_push();
    idle(1);
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL win_frozen: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_deuce();
    exp_t e, o;
    logic [0:23] seq_a;
    seq_a = {20'b10101010101010101010, 4'b1011};
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    model_start(); model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL done_restart: got %s, expected %s", fmt(o), fmt(e)); end
    for (int i = 0; i < 24; i++) begin
      pulse(1'b0, 1'b0, seq_a[i], ~seq_a[i]);
      model_point(seq_a[i], ~seq_a[i]); model_push();
      idle(1);
      e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL deuce_pt%0d: got %s, expected %s", i + 1, fmt(o), fmt(e)); end
      idle(6);
    end
  endtask

  task automatic test_replay_hold();
    exp_t e, o;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    model_start(); model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_start: got %s, expected %s", fmt(o), fmt(e)); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    model_point(1'b1, 1'b0); model_push();
    idle(1);
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_pt1: got %s, expected %s", fmt(o), fmt(e)); end
    idle(6);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_both: got %s, expected %s", fmt(o), fmt(e)); end
    // Counted only if the double press left the FSM in PLAY.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    model_point(1'b1, 1'b0); model_push();
    idle(1);
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_still_play: got %s, expected %s", fmt(o), fmt(e)); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_hold_ignored: got %s, expected %s", fmt(o), fmt(e)); end
    idle(2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_too_early: got %s, expected %s", fmt(o), fmt(e)); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    model_point(1'b0, 1'b1); model_push();
    idle(1);
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rep_min_spacing: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    logic [0:8] seq_a;
    seq_a = 9'b111000000;
    idle(6);
    for (int i = 0; i < 9; i++) begin
      pulse(1'b0, 1'b0, seq_a[i], ~seq_a[i]);
      model_point(seq_a[i], ~seq_a[i]); model_push();
      idle(1);
      e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL mid_pt%0d: got %s, expected %s", i + 1, fmt(o), fmt(e)); end
      if (i != 8) idle(6);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL start_ignored: got %s, expected %s", fmt(o), fmt(e)); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset(); model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mid_reset: got %s, expected %s", fmt(o), fmt(e)); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    model_push();
    e = sb_q.pop_front(); o = obs(1'b0); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL post_reset_idle: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  // Plays n alternating points (A first) on the short-timer instance; the last
  // comparison lands one cycle after the final CHECK.
  task automatic test_timeout(input string tag, input int n, input bit late_point);
    exp_t e, o;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    model_start(); model_push();
    e = sb_q.pop_front(); o = obs(1'b1); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL %s_start: got %s, expected %s", tag, fmt(o), fmt(e)); end
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0, (i % 2 == 0), (i % 2 == 1));
      model_point((i % 2 == 0), (i % 2 == 1)); model_push();
      idle(1);
      e = sb_q.pop_front(); o = obs(1'b1); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL %s_pt%0d: got %s, expected %s", tag, i + 1, fmt(o), fmt(e)); end
      if (i != n - 1) idle(6);
    end
    if (n == 6) begin
      // Positioned just after the edge that sets the timeout flag.
      idle(8);
      model_push();
      e = sb_q.pop_front(); o = obs(1'b1); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL %s_pre_expiry: got %s, expected %s", tag, fmt(o), fmt(e)); end
      if (late_point) begin
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        model_point(1'b1, 1'b0);
      end
    end
    idle(1);
    model_timeout(); model_push();
    e = sb_q.pop_front(); o = obs(1'b1); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL %s_expired: got %s, expected %s", tag, fmt(o), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_straight_win();
    test_deuce();
    test_replay_hold();
    test_reset_mid();
    test_timeout("tdraw", 6, 1'b0);
    test_timeout("tlead", 7, 1'b0);
    test_timeout("texpiry_pt", 6, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
